// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared pipeline definitions used by fetch, execute and the
//               hazard unit: PC-source encodings, canonical NOP and the
//               default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // Default datapath / address width of the pipeline
    localparam int DEFAULT_XLEN = 32;

    // Next-PC source encodings driven by the execute stage
    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_JALR = 2'b10;

    // addi x0, x0, 0 - the bubble inserted into decode on a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Priority is flush > stall >
//               capture. A flush loads a NOP bubble with the valid bit
//               cleared; a stall holds every field; otherwise the fetched
//               word and its PC are captured.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;
    logic [XLEN-1:0] w_pc_plus4;

    // Link address of the captured instruction, wrapping modulo 2^XLEN
    always_comb begin
        w_pc_plus4 = i_pc + c_pc_step;
    end

    // Pipeline register: bubble on flush, hold on stall, else capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= c_pc_step;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= c_pc_step;
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC register, next-PC
//               selection (sequential / branch-jal / jalr), redirect target
//               alignment, a sticky misaligned-target flag, saturating
//               fetch and flush counters, and the IF/ID register feeding
//               decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pc_stall,
    input  logic             i_if_id_stall,
    input  logic             i_if_id_flush,
    input  logic [1:0]       i_pc_src_e,
    input  logic [XLEN-1:0]  i_pc_target_e,
    input  logic [XLEN-1:0]  i_alu_res_e,
    output logic [XLEN-1:0]  o_imem_addr,
    input  logic [31:0]      i_imem_rdata,
    output logic [31:0]      o_instr_d,
    output logic [XLEN-1:0]  o_pc_d,
    output logic [XLEN-1:0]  o_pc_plus4_d,
    output logic             o_valid_d,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_fetch_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [XLEN-1:0]  c_pc_step    = XLEN'(4);
    localparam logic [XLEN-1:0]  c_jalr_mask  = ~XLEN'(1);
    localparam logic [XLEN-1:0]  c_align_mask = ~XLEN'(3);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    logic [XLEN-1:0]  r_pc;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_redirect;
    logic [XLEN-1:0]  w_target_raw;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_seq_pc;
    logic             w_misalign_hit;
    logic             w_capture;

    // Redirect target selection; jalr drops bit 0 before the alignment check
    always_comb begin
        w_redirect   = 1'b0;
        w_target_raw = '0;
        case (i_pc_src_e)
            PC_SRC_BR: begin
                w_redirect   = 1'b1;
                w_target_raw = i_pc_target_e;
            end
            PC_SRC_JALR: begin
                w_redirect   = 1'b1;
                w_target_raw = i_alu_res_e & c_jalr_mask;
            end
            default: begin
                w_redirect   = 1'b0;
                w_target_raw = '0;
            end
        endcase
    end

    // Word-align the target and flag a redirect that had bit 1 set
    always_comb begin
        w_target       = w_target_raw & c_align_mask;
        w_misalign_hit = w_redirect & w_target_raw[1];
        w_seq_pc       = r_pc + c_pc_step;
    end

    // A new instruction enters decode only when neither flushed nor stalled
    always_comb begin
        w_capture = ~i_if_id_flush & ~i_if_id_stall;
    end

    // PC register: a redirect overrides the load-use stall
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_target;
        end else if (!i_pc_stall) begin
            r_pc <= w_seq_pc;
        end
    end

    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_hit) begin
            r_misalign <= 1'b1;
        end
    end

    // Saturating count of instructions captured into IF/ID
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_cnt <= '0;
        end else if (w_capture && (r_fetch_cnt != c_cnt_max)) begin
            r_fetch_cnt <= r_fetch_cnt + c_cnt_one;
        end
    end

    // Saturating count of cycles with the IF/ID flush asserted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush_cnt <= '0;
        end else if (i_if_id_flush && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    if_id_reg #(
        .XLEN       (XLEN)
    ) u_if_id_reg (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_if_id_flush),
        .i_stall    (i_if_id_stall),
        .i_instr    (i_imem_rdata),
        .i_pc       (r_pc),
        .o_instr    (o_instr_d),
        .o_pc       (o_pc_d),
        .o_pc_plus4 (o_pc_plus4_d),
        .o_valid    (o_valid_d)
    );

    assign o_imem_addr = r_pc;
    assign o_misalign  = r_misalign;
    assign o_fetch_cnt = r_fetch_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A behavioural model of
//               the fetch stage is advanced once per clock and compared
//               with every DUT output; directed phases pin literal values,
//               a randomized phase exercises redirects, stalls and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pc_stall = 1'b0;
    logic             if_id_stall = 1'b0;
    logic             if_id_flush = 1'b0;
    logic [1:0]       pc_src_e = 2'b00;
    logic [XLEN-1:0]  pc_target_e = '0;
    logic [XLEN-1:0]  alu_res_e = '0;
    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr_d;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4_d;
    logic             valid_d;
    logic             misalign;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Instruction memory contents: address scrambled by a per-phase key
    logic [31:0]      key = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ key;

    fetch_stage #(
        .XLEN         (XLEN),
        .RESET_PC     (32'h0000_0000),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pc_stall   (pc_stall),
        .i_if_id_stall(if_id_stall),
        .i_if_id_flush(if_id_flush),
        .i_pc_src_e   (pc_src_e),
        .i_pc_target_e(pc_target_e),
        .i_alu_res_e  (alu_res_e),
        .o_imem_addr  (imem_addr),
        .i_imem_rdata (imem_rdata),
        .o_instr_d    (instr_d),
        .o_pc_d       (pc_d),
        .o_pc_plus4_d (pc_plus4_d),
        .o_valid_d    (valid_d),
        .o_misalign   (misalign),
        .o_fetch_cnt  (fetch_cnt),
        .o_flush_cnt  (flush_cnt)
    );

    // ------------------------------------------------------------------
    // Behavioural model state
    // ------------------------------------------------------------------
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0000_0013;
    logic [31:0] m_pc_d  = 32'h0;
    logic [31:0] m_pc4   = 32'h4;
    logic        m_valid = 1'b0;
    logic        m_mis   = 1'b0;
    int          m_fcnt  = 0;
    int          m_flcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0000_0013;
        m_pc_d  = 32'h0;
        m_pc4   = 32'h4;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_fcnt  = 0;
        m_flcnt = 0;
    endtask

    // One clock of fetch behaviour, from the sampled inputs
    task automatic model_step();
        logic [31:0] word;
        logic [31:0] tgt;
        logic        redir;
        word  = m_pc ^ key;
        redir = (pc_src_e == 2'd1) || (pc_src_e == 2'd2);
        tgt   = (pc_src_e == 2'd1) ? pc_target_e : (alu_res_e & 32'hFFFF_FFFE);
        // decode slot
        if (if_id_flush) begin
            m_instr = 32'h0000_0013;
            m_pc_d  = 32'h0;
            m_pc4   = 32'h4;
            m_valid = 1'b0;
            if (m_flcnt < CMAX) m_flcnt++;
        end else if (!if_id_stall) begin
            m_instr = word;
            m_pc_d  = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            if (m_fcnt < CMAX) m_fcnt++;
        end
        // program counter
        if (redir) begin
            if (tgt[1]) m_mis = 1'b1;
            m_pc = {tgt[31:2], 2'b00};
        end else if (!pc_stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("imem_addr",   64'(imem_addr),  64'(m_pc));
        check("instr_d",     64'(instr_d),    64'(m_instr));
        check("pc_d",        64'(pc_d),       64'(m_pc_d));
        check("pc_plus4_d",  64'(pc_plus4_d), 64'(m_pc4));
        check("valid_d",     64'(valid_d),    64'(m_valid));
        check("misalign",    64'(misalign),   64'(m_mis));
        check("fetch_cnt",   64'(fetch_cnt),  64'(m_fcnt));
        check("flush_cnt",   64'(flush_cnt),  64'(m_flcnt));
    endtask

    // Model advance and full comparison on every clock (and on reset)
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
        #2;
        compare_all();
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                       input logic ps, input logic is, input logic fl);
        pc_src_e    = src;
        pc_target_e = tgt;
        alu_res_e   = alu;
        pc_stall    = ps;
        if_id_stall = is;
        if_id_flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        int r;
        logic [1:0] src;
        logic st;
        for (int i = 0; i < n; i++) begin
            r   = int'($urandom_range(0, 9));
            src = (r < 6) ? 2'd0 : 2'(r - 6);
            st  = ($urandom_range(0, 3) == 0);
            cyc(src,
                $urandom & (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF),
                $urandom & (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFD : 32'hFFFF_FFFF),
                st,
                st ^ ($urandom_range(0, 7) == 0),
                (src == 2'd1 || src == 2'd2) ? 1'b1 : ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("lit_reset_addr",  64'(imem_addr), 64'h0);
        check("lit_reset_instr", 64'(instr_d),   64'h13);
        check("lit_reset_pc4",   64'(pc_plus4_d), 64'h4);
        check("lit_reset_valid", 64'(valid_d),   64'h0);

        // Sequential fetch with imem returning its own address
        idle();
        check("lit_seq1_addr",  64'(imem_addr), 64'h4);
        check("lit_seq1_instr", 64'(instr_d),   64'h0);
        check("lit_seq1_pc_d",  64'(pc_d),      64'h0);
        check("lit_seq1_valid", 64'(valid_d),   64'h1);
        idle();
        check("lit_seq2_addr",  64'(imem_addr), 64'h8);
        idle();
        check("lit_seq3_fcnt",  64'(fetch_cnt), 64'h3);
        idle();
        check("lit_seq4_addr",  64'(imem_addr), 64'h10);
        check("lit_seq4_instr", 64'(instr_d),   64'hC);

        // Two-cycle stall at PC 0x10
        for (int i = 0; i < 2; i++) begin
            cyc(2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            check("lit_stall_addr",  64'(imem_addr), 64'h10);
            check("lit_stall_instr", 64'(instr_d),   64'hC);
            check("lit_stall_fcnt",  64'(fetch_cnt), 64'h4);
        end
        idle();
        check("lit_unstall_addr",  64'(imem_addr), 64'h14);
        check("lit_unstall_instr", 64'(instr_d),   64'h10);

        // Branch redirect with flush
        cyc(2'd1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1);
        check("lit_br_addr",   64'(imem_addr), 64'h100);
        check("lit_br_instr",  64'(instr_d),   64'h13);
        check("lit_br_valid",  64'(valid_d),   64'h0);
        check("lit_br_flcnt",  64'(flush_cnt), 64'h1);
        idle();
        check("lit_br_tinstr", 64'(instr_d),   64'h100);
        check("lit_br_tpc",    64'(pc_d),      64'h100);

        // jalr targets: bit 0 dropped silently, bit 1 flagged
        cyc(2'd2, 32'h0, 32'h201, 1'b0, 1'b0, 1'b1);
        check("lit_jalr_addr", 64'(imem_addr), 64'h200);
        check("lit_jalr_mis",  64'(misalign),  64'h0);
        cyc(2'd2, 32'h0, 32'h206, 1'b0, 1'b0, 1'b1);
        check("lit_jalr2_addr", 64'(imem_addr), 64'h204);
        check("lit_jalr2_mis",  64'(misalign),  64'h1);
        idle();
        idle();
        check("lit_mis_sticky", 64'(misalign), 64'h1);

        // Redirect and flush win over both stalls
        cyc(2'd1, 32'h40, 32'h0, 1'b1, 1'b1, 1'b1);
        check("lit_prio_addr",  64'(imem_addr), 64'h40);
        check("lit_prio_instr", 64'(instr_d),   64'h13);
        check("lit_prio_valid", 64'(valid_d),   64'h0);

        // Counter saturation
        for (int i = 0; i < 20; i++) cyc(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("lit_flcnt_sat", 64'(flush_cnt), 64'(CMAX));
        for (int i = 0; i < 12; i++) idle();
        check("lit_fcnt_sat", 64'(fetch_cnt), 64'(CMAX));

        // Randomized traffic
        key = $urandom;
        random_run(400);

        // Asynchronous reset mid-cycle at PC 0x80
        cyc(2'd1, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("lit_pre_rst_addr", 64'(imem_addr), 64'h80);
        #2 rst = 1'b1;
        #1;
        check("lit_arst_addr",  64'(imem_addr), 64'h0);
        check("lit_arst_valid", 64'(valid_d),   64'h0);
        check("lit_arst_fcnt",  64'(fetch_cnt), 64'h0);
        check("lit_arst_flcnt", 64'(flush_cnt), 64'h0);
        check("lit_arst_mis",   64'(misalign),  64'h0);
        @(negedge clk);
        rst = 1'b0;

        key = $urandom;
        random_run(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
